// File: rtl/instram_pkg.sv
// Shared definitions for the instruction-RAM write scheduler: address width,
// FSM state type and the RAM address wrap helper.
package instram_pkg;

    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned ADR_BITS = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    // Keep the low 'aw' address bits and force the rest to zero, so every
    // address lands inside the RAM and the unused upper port bits stay 0.
    function automatic logic [ADR_BITS-1:0] addr_wrap(
        input logic [ADR_BITS-1:0] adr,
        input int unsigned         aw
    );
        logic [ADR_BITS-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ADR_BITS; i++) begin
            if (i < aw) begin
                r[i] = adr[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/instram_wr_hold.sv
// One-entry CPU write hold register. Captures a CPU write only while the CPU
// is allowed to write, flags (sticky) any write attempted while held off.
module instram_wr_hold
    import instram_pkg::*;
#(
    parameter int unsigned ADR_BITS = instram_pkg::ADR_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cpu_we,
    input  logic [ADR_BITS-1:0] cpu_adr,
    input  logic [7:0]          cpu_data,
    input  logic                cpu_wait_n,
    input  logic                pop,
    output logic                full,
    output logic                full_next,
    output logic [ADR_BITS-1:0] hold_adr,
    output logic [7:0]          hold_data,
    output logic                cpu_err
);

    logic capture;
    logic violate;

    // Accepted CPU writes and dropped (protocol-violating) writes
    always_comb begin
        capture   = cpu_we && cpu_wait_n;
        violate   = cpu_we && !cpu_wait_n;
        full_next = capture || (full && !pop);
    end

    // Hold register contents, full flag and sticky error flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full      <= 1'b0;
            hold_adr  <= '0;
            hold_data <= '0;
            cpu_err   <= 1'b0;
        end else begin
            full <= full_next;
            if (capture) begin
                hold_adr  <= cpu_adr;
                hold_data <= cpu_data;
            end
            if (violate) begin
                cpu_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instram_wr_sched.sv
// Instruction RAM write-port scheduler: shares the RAM write port between a
// byte-stream loader and CPU single writes, sequences bulk loads from a base
// address and drives the RAM with data leading address/select by one cycle.
module instram_wr_sched
    import instram_pkg::*;
#(
    parameter int unsigned ADDR_W   = instram_pkg::ADDR_W,
    parameter int unsigned ADR_BITS = instram_pkg::ADR_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ld_start,
    input  logic [ADR_BITS-1:0] ld_base,
    input  logic [ADR_BITS-1:0] ld_len,
    input  logic                ld_valid,
    input  logic [7:0]          ld_data,
    output logic                ld_ready,
    output logic                ld_busy,
    output logic                ld_done,
    input  logic                cpu_we,
    input  logic [ADR_BITS-1:0] cpu_adr,
    input  logic [7:0]          cpu_data,
    output logic                cpu_wait_n,
    output logic                cpu_err,
    output logic [ADR_BITS-1:0] ram_adr_w,
    output logic [7:0]          ram_data,
    output logic                ram_rwn,
    output logic                ram_cs
);

    state_t              state_q;
    state_t              state_d;
    logic [ADR_BITS-1:0] base_q;
    logic [ADR_BITS-1:0] base_d;
    logic [ADR_BITS-1:0] len_q;
    logic [ADR_BITS-1:0] len_d;
    logic [ADR_BITS-1:0] cnt_q;
    logic [ADR_BITS-1:0] cnt_d;
    logic                done_d;
    logic                ld_acc;

    logic                issue;
    logic [ADR_BITS-1:0] issue_adr;
    logic [7:0]          issue_data;

    logic                s0_valid_q;
    logic [ADR_BITS-1:0] s0_adr_q;

    logic                hold_full;
    logic                hold_full_next;
    logic                hold_pop;
    logic [ADR_BITS-1:0] hold_adr;
    logic [7:0]          hold_data;

    instram_wr_hold #(
        .ADR_BITS(ADR_BITS)
    ) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_data  (cpu_data),
        .cpu_wait_n(cpu_wait_n),
        .pop       (hold_pop),
        .full      (hold_full),
        .full_next (hold_full_next),
        .hold_adr  (hold_adr),
        .hold_data (hold_data),
        .cpu_err   (cpu_err)
    );

    // Next-state, issue-slot arbitration and load sequencing
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        ld_acc     = 1'b0;
        issue      = 1'b0;
        issue_adr  = '0;
        issue_data = '0;
        hold_pop   = 1'b0;

        // A full hold register always takes the slot; ld_ready is already
        // low in that cycle, so the loader cannot collide with it.
        if (hold_full) begin
            issue      = 1'b1;
            issue_adr  = addr_wrap(hold_adr, ADDR_W);
            issue_data = hold_data;
            hold_pop   = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (ld_start) begin
                    if (ld_len != '0) begin
                        base_d  = ld_base;
                        len_d   = ld_len;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                ld_acc = ld_valid && ld_ready && !hold_full;
                if (ld_acc) begin
                    issue      = 1'b1;
                    issue_adr  = addr_wrap(base_q + cnt_q, ADDR_W);
                    issue_data = ld_data;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Once S0 is empty the last write is sitting in S1 this
                // cycle, so the done pulse lands right after its ram_cs cycle.
                if (!s0_valid_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, load descriptor and byte counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered handshake and status outputs, derived from next-cycle state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ld_ready   <= 1'b0;
            ld_busy    <= 1'b0;
            ld_done    <= 1'b0;
            cpu_wait_n <= 1'b1;
        end else begin
            ld_ready   <= (state_d == LOAD) && !hold_full_next;
            ld_busy    <= (state_d != IDLE);
            ld_done    <= done_d;
            cpu_wait_n <= (state_d == IDLE) && !hold_full_next;
        end
    end

    // Issue stage S0: write data goes to the RAM one cycle ahead of address
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s0_valid_q <= 1'b0;
            s0_adr_q   <= '0;
            ram_data   <= '0;
        end else begin
            s0_valid_q <= issue;
            if (issue) begin
                s0_adr_q <= issue_adr;
                ram_data <= issue_data;
            end
        end
    end

    // Issue stage S1: address, select and write strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ram_adr_w <= '0;
            ram_cs    <= 1'b0;
            ram_rwn   <= 1'b1;
        end else begin
            ram_cs  <= s0_valid_q;
            ram_rwn <= !s0_valid_q;
            if (s0_valid_q) begin
                ram_adr_w <= s0_adr_q;
            end
        end
    end

endmodule
